// File: rtl/sr_latch_pkg.sv
// sr_latch_pkg
// Shared definitions for the clocked SR latch emulation:
//   - cmd_e      : decoded command for one channel, built as {s, r}
//   - STATE_RST  : value of the stored state bit while in reset
//   - SYNC_RST   : value loaded into every synchronizer flop in reset
//                  (1 = the inactive level of the active-low inputs)
//   - decode_cmd : maps one synchronized (s, r) pair to a command

package sr_latch_pkg;

    typedef enum logic [1:0] {
        CMD_FORBID = 2'b00,
        CMD_SET    = 2'b01,
        CMD_RESET  = 2'b10,
        CMD_HOLD   = 2'b11
    } cmd_e;

    localparam logic STATE_RST = 1'b0;
    localparam logic SYNC_RST  = 1'b1;

    // The encoding is chosen so that the raw {s, r} pair is already the command.
    function automatic cmd_e decode_cmd(input logic s, input logic r);
        return cmd_e'({s, r});
    endfunction

endpackage

// File: rtl/sr_sync_cell.sv
// sr_sync_cell
// Single-bit synchronizer: a STAGES-deep flop chain that brings one
// asynchronous input into the clk domain.
// Ports:
//   clk    : sampling clock
//   rst_n  : asynchronous active-low reset, loads every flop with SYNC_RST
//   d      : asynchronous input bit
//   q      : synchronized output bit
// With STAGES = 0 the input is assumed to be synchronous already and is
// passed straight through.

module sr_sync_cell
    import sr_latch_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    generate
        if (STAGES == 0) begin : g_bypass
            // Clock and reset are intentionally unused in the bypass case.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign q = d;
        end else begin : g_chain
            logic [STAGES-1:0] chain;

            // Bit 0 takes the raw input; each later bit takes its predecessor.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    chain <= {STAGES{SYNC_RST}};
                end else begin
                    chain[0] <= d;
                    for (int i = 1; i < STAGES; i++) begin
                        chain[i] <= chain[i-1];
                    end
                end
            end

            assign q = chain[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/sr_latch_sync.sv
// sr_latch_sync
// Clocked, multi-channel emulation of a NAND-style SR latch with active-low
// set/reset requests. Every channel stores one bit and drives registered,
// complementary outputs. The forbidden (s=0, r=0) combination is flagged per
// channel and collected into a sticky flag.
// Ports:
//   clk            : single clock, all updates on the rising edge
//   rst_n          : asynchronous active-low reset
//   r[WIDTH]       : active-low reset request per channel
//   s[WIDTH]       : active-low set request per channel
//   clr_illegal    : synchronous pulse that clears illegal_sticky
//   q[WIDTH]       : registered latch state
//   q_bar[WIDTH]   : registered complement (both high while forbidden)
//   illegal[WIDTH] : high while the synchronized inputs are both low
//   illegal_sticky : set by any illegal bit, held until cleared

module sr_latch_sync
    import sr_latch_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] s,
    input  logic             clr_illegal,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] illegal,
    output logic             illegal_sticky
);

    logic [WIDTH-1:0] s_sync;
    logic [WIDTH-1:0] r_sync;
    cmd_e             cmd [WIDTH];

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] q_bar_nxt;
    logic [WIDTH-1:0] illegal_nxt;

    // One synchronizer per input bit, then a per-channel decode.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_chan
            sr_sync_cell #(
                .STAGES(SYNC_STAGES)
            ) u_sync_s (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (s[i]),
                .q     (s_sync[i])
            );

            sr_sync_cell #(
                .STAGES(SYNC_STAGES)
            ) u_sync_r (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (r[i]),
                .q     (r_sync[i])
            );

            assign cmd[i] = decode_cmd(s_sync[i], r_sync[i]);
        end
    endgenerate

    // FORBIDDEN drives both outputs high but leaves the stored bit alone, so a
    // later HOLD falls back to the pre-forbidden value.
    always_comb begin
        state_nxt   = state;
        q_nxt       = state;
        q_bar_nxt   = ~state;
        illegal_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (cmd[i])
                CMD_SET: begin
                    state_nxt[i] = 1'b1;
                    q_nxt[i]     = 1'b1;
                    q_bar_nxt[i] = 1'b0;
                end
                CMD_RESET: begin
                    state_nxt[i] = 1'b0;
                    q_nxt[i]     = 1'b0;
                    q_bar_nxt[i] = 1'b1;
                end
                CMD_FORBID: begin
                    q_nxt[i]       = 1'b1;
                    q_bar_nxt[i]   = 1'b1;
                    illegal_nxt[i] = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= {WIDTH{STATE_RST}};
            q       <= {WIDTH{STATE_RST}};
            q_bar   <= {WIDTH{~STATE_RST}};
            illegal <= '0;
        end else begin
            state   <= state_nxt;
            q       <= q_nxt;
            q_bar   <= q_bar_nxt;
            illegal <= illegal_nxt;
        end
    end

    // Sticky flag follows the registered illegal bits; a new forbidden
    // condition wins over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_sticky <= 1'b0;
        end else if (|illegal) begin
            illegal_sticky <= 1'b1;
        end else if (clr_illegal) begin
            illegal_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sr_latch_sync.sv
// tb_sr_latch_sync
// Drives two instances side by side: dut_a with the default two-stage
// synchronizer and dut_b with SYNC_STAGES = 0. A behavioural model delays
// each input vector by the synchronizer depth with a queue and then applies
// the latch truth table per channel.

module tb_sr_latch_sync;

    localparam int W    = 8;
    localparam int SS_A = 2;
    localparam int SS_B = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [W-1:0] s_a, r_a, s_b, r_b;
    logic         clr;

    logic [W-1:0] q_a, qb_a, ill_a;
    logic [W-1:0] q_b, qb_b, ill_b;
    logic         st_a, st_b;

    int checks   = 0;
    int failures = 0;

    sr_latch_sync #(.WIDTH(W), .SYNC_STAGES(SS_A)) dut_a (
        .clk            (clk),
        .rst_n          (rst_n),
        .r              (r_a),
        .s              (s_a),
        .clr_illegal    (clr),
        .q              (q_a),
        .q_bar          (qb_a),
        .illegal        (ill_a),
        .illegal_sticky (st_a)
    );

    sr_latch_sync #(.WIDTH(W), .SYNC_STAGES(SS_B)) dut_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .r              (r_b),
        .s              (s_b),
        .clr_illegal    (clr),
        .q              (q_b),
        .q_bar          (qb_b),
        .illegal        (ill_b),
        .illegal_sticky (st_b)
    );

    // Reference model state, index 0 = dut_a, index 1 = dut_b.
    logic [W-1:0]   m_state [2];
    logic [W-1:0]   m_q     [2];
    logic [W-1:0]   m_qb    [2];
    logic [W-1:0]   m_ill   [2];
    logic           m_st    [2];
    logic [2*W-1:0] dq_a [$];
    logic [2*W-1:0] dq_b [$];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = '0;
            m_q[k]     = '0;
            m_qb[k]    = '1;
            m_ill[k]   = '0;
            m_st[k]    = 1'b0;
        end
        dq_a.delete();
        dq_b.delete();
        repeat (SS_A) dq_a.push_back('1);
        repeat (SS_B) dq_b.push_back('1);
    endtask

    // Latch truth table applied to one delayed input vector.
    task automatic model_apply(input int k, input logic [2*W-1:0] sr, input logic c);
        logic [W-1:0] sv;
        logic [W-1:0] rv;
        sv = sr[2*W-1:W];
        rv = sr[W-1:0];
        m_st[k] = (m_ill[k] != '0) || (m_st[k] && !c);
        for (int i = 0; i < W; i++) begin
            if (!sv[i] && !rv[i]) begin
                m_q[k][i]   = 1'b1;
                m_qb[k][i]  = 1'b1;
                m_ill[k][i] = 1'b1;
            end else begin
                m_ill[k][i] = 1'b0;
                if (!sv[i])      m_state[k][i] = 1'b1;
                else if (!rv[i]) m_state[k][i] = 1'b0;
                m_q[k][i]  = m_state[k][i];
                m_qb[k][i] = ~m_state[k][i];
            end
        end
    endtask

    task automatic model_step();
        dq_a.push_back({s_a, r_a});
        dq_b.push_back({s_b, r_b});
        model_apply(0, dq_a.pop_front(), clr);
        model_apply(1, dq_b.pop_front(), clr);
    endtask

    task automatic compareAll();
        checkOutput("q_a",      q_a,   m_q[0]);
        checkOutput("q_bar_a",  qb_a,  m_qb[0]);
        checkOutput("illegal_a", ill_a, m_ill[0]);
        checkOutput("sticky_a", st_a,  m_st[0]);
        checkOutput("q_b",      q_b,   m_q[1]);
        checkOutput("q_bar_b",  qb_b,  m_qb[1]);
        checkOutput("illegal_b", ill_b, m_ill[1]);
        checkOutput("sticky_b", st_b,  m_st[1]);
    endtask

    // One clock: the edge consumes the inputs already on the pins, then the
    // new vector is driven and outputs are compared on the falling edge.
    task automatic applyStimulus(input logic [W-1:0] sa, input logic [W-1:0] ra,
                                 input logic [W-1:0] sb, input logic [W-1:0] rb,
                                 input logic c);
        @(posedge clk);
        model_step();
        #1;
        s_a = sa; r_a = ra; s_b = sb; r_b = rb; clr = c;
        @(negedge clk);
        compareAll();
    endtask

    task automatic holdStimulus(input logic [W-1:0] sa, input logic [W-1:0] ra, input logic c, input int n);
        for (int j = 0; j < n; j++) applyStimulus(sa, ra, 8'hFF, 8'hFF, c);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_q_a"},   q_a,   8'h00);
        checkOutput({tag, "_qb_a"},  qb_a,  8'hFF);
        checkOutput({tag, "_ill_a"}, ill_a, 8'h00);
        checkOutput({tag, "_st_a"},  st_a,  1'b0);
        checkOutput({tag, "_q_b"},   q_b,   8'h00);
        checkOutput({tag, "_qb_b"},  qb_b,  8'hFF);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat_a;
        int lat_b;

        rst_n = 1'b0;
        s_a = '1; r_a = '1; s_b = '1; r_b = '1; clr = 1'b0;
        model_reset();
        #12;
        checkResetValues("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Latency of a set on channel 0, counted in rising edges.
        lat_a = 0;
        lat_b = 0;
        applyStimulus(8'hFE, 8'hFF, 8'hFE, 8'hFF, 1'b0);
        for (int e = 1; e <= 10; e++) begin
            applyStimulus(8'hFE, 8'hFF, 8'hFE, 8'hFF, 1'b0);
            if (q_a[0] && lat_a == 0) lat_a = e;
            if (q_b[0] && lat_b == 0) lat_b = e;
        end
        checkOutput("latency_a", lat_a, SS_A + 1);
        checkOutput("latency_b", lat_b, SS_B + 1);

        // Basic set / hold / reset / hold on channel 0.
        holdStimulus(8'hFF, 8'hFF, 1'b0, 5);
        checkOutput("hold1_q0", q_a[0], 1'b1);
        holdStimulus(8'hFF, 8'hFE, 1'b0, 5);
        checkOutput("reset_q0",  q_a[0],  1'b0);
        checkOutput("reset_qb0", qb_a[0], 1'b1);
        holdStimulus(8'hFF, 8'hFF, 1'b0, 5);
        checkOutput("hold0_q0", q_a[0], 1'b0);

        // Forbidden on channel 3 from q=1, then back to hold.
        holdStimulus(8'hF7, 8'hFF, 1'b0, 5);
        holdStimulus(8'hF7, 8'hF7, 1'b0, 5);
        checkOutput("forbid_q3",   q_a[3],   1'b1);
        checkOutput("forbid_qb3",  qb_a[3],  1'b1);
        checkOutput("forbid_ill3", ill_a[3], 1'b1);
        checkOutput("forbid_st",   st_a,     1'b1);
        holdStimulus(8'hFF, 8'hFF, 1'b0, 5);
        checkOutput("unforbid_q3",   q_a[3],   1'b1);
        checkOutput("unforbid_qb3",  qb_a[3],  1'b0);
        checkOutput("unforbid_ill3", ill_a[3], 1'b0);
        checkOutput("unforbid_st",   st_a,     1'b1);

        // Sticky clear alone, then clear coinciding with a new forbidden.
        applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
        applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        checkOutput("clr_st", st_a, 1'b0);
        holdStimulus(8'hFE, 8'hFE, 1'b1, 6);
        checkOutput("clr_vs_set_st", st_a, 1'b1);
        holdStimulus(8'hFF, 8'hFF, 1'b0, 3);

        // Even channels set, odd channels reset, all at once.
        holdStimulus(8'hAA, 8'h55, 1'b0, 5);
        checkOutput("indep_q",  q_a,  8'h55);
        checkOutput("indep_qb", qb_a, 8'hAA);

        // Single-cycle set pulse on channel 1 of the unsynchronized instance.
        applyStimulus(8'hFF, 8'hFF, 8'hFD, 8'hFF, 1'b0);
        applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        checkOutput("pulse_q1", q_b[1], 1'b1);
        for (int j = 0; j < 3; j++) applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        checkOutput("pulse_hold_q1", q_b[1], 1'b1);

        // Reset asserted mid-run with channel 0 set.
        holdStimulus(8'hFE, 8'hFF, 1'b0, 5);
        checkOutput("pre_rst_q0", q_a[0], 1'b1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        s_a = '1; r_a = '1; s_b = '1; r_b = '1; clr = 1'b0;
        #1;
        checkResetValues("midrun");
        checkOutput("midrun_ill_b", ill_b, 8'h00);
        checkOutput("midrun_st_b",  st_b,  1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic on both instances.
        for (int n = 0; n < 400; n++) begin
            logic [W-1:0] sa, ra, sb, rb;
            sa = W'($urandom);
            ra = W'($urandom) | W'($urandom);
            sb = W'($urandom) | W'($urandom);
            rb = W'($urandom);
            applyStimulus(sa, ra, sb, rb, ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
